// File: rtl/reg_arbiter_2b.sv
// Three-requester round-robin arbiter in front of a four-entry, 2-bit register
// bank. A winner's address and data are captured on entry to WRITE, the bank
// write-enable is held for WR_CYCLES cycles, then a one-cycle ack is returned.
// All state advances on the falling edge of CLK; every output is either a
// flop or a decode of flops, so req/wr_* never reach the outputs directly.
module reg_arbiter_2b #(
  parameter int WR_CYCLES = 1  // bank write-enable pulse width, 1..4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] req,
  input  logic [1:0] wr_addr0,
  input  logic [1:0] wr_addr1,
  input  logic [1:0] wr_addr2,
  input  logic [1:0] wr_dat0,
  input  logic [1:0] wr_dat1,
  input  logic [1:0] wr_dat2,
  output logic [2:0] grant,
  output logic [2:0] ack,
  output logic [3:0] bank_we,
  output logic [1:0] bank_dat,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  // Counter preload: WRITE ends on the edge where the counter is already 0.
  localparam logic [1:0] CNT_LOAD = 2'(WR_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] cnt;
  logic [1:0] last_winner;  // also the current owner while WRITE/ACK
  logic [1:0] addr_q;
  logic [1:0] dat_q;

  logic [1:0] pick;
  logic [1:0] pick_addr;
  logic [1:0] pick_dat;

  // Round-robin choice: search starts one past the previous winner.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick = last_winner;
    case (last_winner)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Route the chosen requester's address and data toward the capture flops.
  always_comb begin
    pick_addr = wr_addr0;
    pick_dat  = wr_dat0;
    case (pick)
      2'd1: begin
        pick_addr = wr_addr1;
        pick_dat  = wr_dat1;
      end
      2'd2: begin
        pick_addr = wr_addr2;
        pick_dat  = wr_dat2;
      end
      default: begin
        pick_addr = wr_addr0;
        pick_dat  = wr_dat0;
      end
    endcase
  end

  // Control FSM, write counter and captured transaction, on the falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      last_winner <= 2'd2;
      addr_q      <= 2'd0;
      dat_q       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 3'b000) begin
            state       <= WRITE;
            cnt         <= CNT_LOAD;
            last_winner <= pick;
            addr_q      <= pick_addr;
            dat_q       <= pick_dat;
          end
        end
        WRITE: begin
          if (cnt == 2'd0) begin
            state <= ACK;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only; reset clears these at once.
  always_comb begin
    grant   = 3'b000;
    ack     = 3'b000;
    bank_we = 4'b0000;
    if (state == WRITE) begin
      grant   = 3'b001 << last_winner;
      bank_we = 4'b0001 << addr_q;
    end
    if (state == ACK) begin
      ack = 3'b001 << last_winner;
    end
  end

  assign bank_dat = dat_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_reg_arbiter_2b.sv
// Bench for reg_arbiter_2b: two instances (WR_CYCLES=1 and 4) share all
// inputs. A transaction-level model (remaining-busy-cycles countdown plus a
// rotating search) predicts every output; directed steps add constant checks.
module tb_reg_arbiter_2b;

  logic       CLK;
  logic       RST;
  logic [2:0] req;
  logic [1:0] wr_addr0, wr_addr1, wr_addr2;
  logic [1:0] wr_dat0, wr_dat1, wr_dat2;

  logic [2:0] grant_a, ack_a, grant_b, ack_b;
  logic [3:0] bank_we_a, bank_we_b;
  logic [1:0] bank_dat_a, bank_dat_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  reg_arbiter_2b #(.WR_CYCLES(1)) dut_a (
    .CLK(CLK), .RST(RST), .req(req),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_dat0(wr_dat0), .wr_dat1(wr_dat1), .wr_dat2(wr_dat2),
    .grant(grant_a), .ack(ack_a), .bank_we(bank_we_a),
    .bank_dat(bank_dat_a), .busy(busy_a)
  );

  reg_arbiter_2b #(.WR_CYCLES(4)) dut_b (
    .CLK(CLK), .RST(RST), .req(req),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_dat0(wr_dat0), .wr_dat1(wr_dat1), .wr_dat2(wr_dat2),
    .grant(grant_b), .ack(ack_b), .bank_we(bank_we_b),
    .bank_dat(bank_dat_b), .busy(busy_b)
  );

  // Falling edges at 5, 15, 25 ...; rising edges (sample points) at 10, 20 ...
  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  // Reference model, one slot per instance.
  int wc     [2] = '{1, 4};
  int m_left [2];  // cycles of busy still to come: WR_CYCLES write + 1 ack
  int m_win  [2];
  int m_last [2];
  int m_addr [2];
  int m_dat  [2];

  function automatic int addr_of(input int c);
    return (c == 0) ? int'(wr_addr0) : (c == 1) ? int'(wr_addr1) : int'(wr_addr2);
  endfunction

  function automatic int dat_of(input int c);
    return (c == 0) ? int'(wr_dat0) : (c == 1) ? int'(wr_dat1) : int'(wr_dat2);
  endfunction

  always @(negedge CLK or posedge RST) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        m_left[i] = 0;
        m_win[i]  = 0;
        m_last[i] = 2;
        m_addr[i] = 0;
        m_dat[i]  = 0;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
      end else if (req != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last[i] + k) % 3;
          if (req[c]) begin
            m_last[i] = c;
            m_win[i]  = c;
            m_addr[i] = addr_of(c);
            m_dat[i]  = dat_of(c);
            m_left[i] = wc[i] + 1;
            break;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_inst(input int i, input string nm, input logic [2:0] g,
                              input logic [2:0] a, input logic [3:0] we,
                              input logic [1:0] d, input logic b);
    int eg, ea, ewe;
    eg  = (m_left[i] >= 2) ? (1 << m_win[i]) : 0;
    ea  = (m_left[i] == 1) ? (1 << m_win[i]) : 0;
    ewe = (m_left[i] >= 2) ? (1 << m_addr[i]) : 0;
    check({nm, ".grant"},    32'(g),  32'(eg));
    check({nm, ".ack"},      32'(a),  32'(ea));
    check({nm, ".bank_we"},  32'(we), 32'(ewe));
    check({nm, ".bank_dat"}, 32'(d),  32'(m_dat[i]));
    check({nm, ".busy"},     32'(b),  32'(m_left[i] != 0));
  endtask

  task automatic compare_all();
    compare_inst(0, "a", grant_a, ack_a, bank_we_a, bank_dat_a, busy_a);
    compare_inst(1, "b", grant_b, ack_b, bank_we_b, bank_dat_b, busy_b);
  endtask

  // Advance one cycle and compare both instances against the model.
  task automatic step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed between falling edges.
  task automatic pulse_reset();
    #1 RST = 1'b1;
    #1 RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    req = 3'b000;
    wr_addr0 = 2'd0; wr_addr1 = 2'd0; wr_addr2 = 2'd0;
    wr_dat0  = 2'd0; wr_dat1  = 2'd0; wr_dat2  = 2'd0;

    // Reset state.
    step();
    step();
    check("rst.busy_a", 32'(busy_a), 32'd0);
    check("rst.bank_we_b", 32'(bank_we_b), 32'd0);
    check("rst.bank_dat_a", 32'(bank_dat_a), 32'd0);
    RST = 1'b0;

    // Single write from requester 0, addr 2, data 3.
    req = 3'b001; wr_addr0 = 2'd2; wr_dat0 = 2'b11;
    step();
    check("single.bank_we", 32'(bank_we_a), 32'h4);
    check("single.bank_dat", 32'(bank_dat_a), 32'h3);
    check("single.grant", 32'(grant_a), 32'h1);
    req = 3'b000;
    step();
    check("single.ack", 32'(ack_a), 32'h1);
    check("single.ack_we", 32'(bank_we_a), 32'h0);
    step();
    check("single.idle_busy", 32'(busy_a), 32'h0);
    check("single.dat_hold", 32'(bank_dat_a), 32'h3);
    repeat (3) step();

    // All three requesting continuously: winners 0,1,2,0 three cycles apart.
    pulse_reset();
    req = 3'b111;
    wr_addr0 = 2'd0; wr_addr1 = 2'd1; wr_addr2 = 2'd3;
    wr_dat0 = 2'd1; wr_dat1 = 2'd2; wr_dat2 = 2'd3;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i % 3 == 2) check("rr.ack", 32'(ack_a), 32'(1 << (((i - 2) / 3) % 3)));
      else check("rr.no_ack", 32'(ack_a), 32'h0);
    end
    req = 3'b000;
    repeat (6) step();

    // WR_CYCLES=4: requester 1 drops req and toggles data mid-write.
    pulse_reset();
    req = 3'b010; wr_addr1 = 2'd1; wr_dat1 = 2'd2;
    step();
    check("long.we1", 32'(bank_we_b), 32'h2);
    step();
    check("long.we2", 32'(bank_we_b), 32'h2);
    req = 3'b000; wr_dat1 = 2'd1;
    step();
    check("long.we3", 32'(bank_we_b), 32'h2);
    check("long.dat3", 32'(bank_dat_b), 32'h2);
    wr_dat1 = 2'd0;
    step();
    check("long.we4", 32'(bank_we_b), 32'h2);
    check("long.dat4", 32'(bank_dat_b), 32'h2);
    step();
    check("long.ack", 32'(ack_b), 32'h2);
    check("long.ack_we", 32'(bank_we_b), 32'h0);
    repeat (2) step();

    // Asynchronous reset during WRITE, then requester 0 wins first.
    req = 3'b010; wr_addr1 = 2'd3; wr_dat1 = 2'd1;
    step();
    #1 RST = 1'b1;
    #1;
    check("arst.we_a", 32'(bank_we_a), 32'h0);
    check("arst.we_b", 32'(bank_we_b), 32'h0);
    check("arst.grant_b", 32'(grant_b), 32'h0);
    check("arst.busy_b", 32'(busy_b), 32'h0);
    check("arst.ack_b", 32'(ack_b), 32'h0);
    compare_all();
    RST = 1'b0;
    req = 3'b011; wr_addr0 = 2'd0; wr_dat0 = 2'd2;
    step();
    check("arst.first_grant", 32'(grant_a), 32'h1);
    check("arst.first_grant_b", 32'(grant_b), 32'h1);
    req = 3'b000;
    repeat (6) step();

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        req      = 3'($urandom_range(0, 7));
        wr_addr0 = 2'($urandom_range(0, 3));
        wr_addr1 = 2'($urandom_range(0, 3));
        wr_addr2 = 2'($urandom_range(0, 3));
        wr_dat0  = 2'($urandom_range(0, 3));
        wr_dat1  = 2'($urandom_range(0, 3));
        wr_dat2  = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 49) == 0) pulse_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
